// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180;
  localparam logic [XLEN-1:0] PC_INC       = 32'd4;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Force a redirect target onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

  // True when a redirect target is not word aligned
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program-counter register: async active-low reset, load enable.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter int unsigned     WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold unless enabled; reset forces the configured start address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, redirect/stall/flush handling and
// the IF/ID pipeline register.
// Optional: define PC_ALIGN_CHECK_EN to trap misaligned redirect targets to
// the exception vector and expose the addr_err flag.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
`ifdef PC_ALIGN_CHECK_EN
  output logic            addr_err,
`endif
  output logic            if_id_valid
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  logic            pc_en;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            target_bad;
  if_id_t          if_id_q;

  // Next-PC selection: branch beats jump beats stall beats sequential
  always_comb begin
    pc_plus4        = pc + PC_INC;
    redirect        = branch_taken | jump;
    redirect_target = branch_taken ? branch_target : jump_target;
    target_bad      = 1'b0;
    pc_en           = redirect | ~stall;
    pc_next         = pc_plus4;
    if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
      target_bad = is_misaligned(redirect_target);
      pc_next    = target_bad ? EXC_VECTOR : redirect_target;
`else
      pc_next    = word_align(redirect_target);
`endif
    end
  end

  pc_reg #(
    .WIDTH    (XLEN),
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .reset(reset),
    .en   (pc_en),
    .d    (pc_next),
    .q    (pc)
  );

  assign imem_addr = pc;

  // IF/ID register: squash on flush/redirect, hold on stall, else capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q <= '{instr: NOP_WORD, pc4: '0, valid: 1'b0};
    end else if (flush || redirect) begin
      if_id_q <= '{instr: NOP_WORD, pc4: pc_plus4, valid: 1'b0};
    end else if (!stall) begin
      if_id_q <= '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
    end
  end

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

`ifdef PC_ALIGN_CHECK_EN
  // One-cycle flag following a trapped misaligned redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= target_bad;
    end
  end
`else
  logic unused_bad;
  assign unused_bad = target_bad;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
`ifdef PC_ALIGN_CHECK_EN
    .addr_err     (addr_err),
`endif
    .if_id_valid  (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  assign imem_rdata = mem(imem_addr);

  typedef struct {
    logic        st;
    logic        fl;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic br,
                              input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid, input logic e_err);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    // Expected state after the edge on which each vector is applied
    vecs[0]  = mk(0,0,0,0,0,0, 32'h4,  mem(32'h0), 32'h4,  1, 0);
    vecs[1]  = mk(0,0,0,0,0,0, 32'h8,  mem(32'h4), 32'h8,  1, 0);
    vecs[2]  = mk(1,0,0,0,0,0, 32'h8,  mem(32'h4), 32'h8,  1, 0);
    vecs[3]  = mk(1,0,0,0,0,0, 32'h8,  mem(32'h4), 32'h8,  1, 0);
    vecs[4]  = mk(0,0,0,0,0,0, 32'hC,  mem(32'h8), 32'hC,  1, 0);
    vecs[5]  = mk(0,0,0,0,0,0, 32'h10, mem(32'hC), 32'h10, 1, 0);
    vecs[6]  = mk(0,1,0,0,0,0, 32'h14, 32'h0,      32'h14, 0, 0);
    vecs[7]  = mk(1,1,0,0,0,0, 32'h14, 32'h0,      32'h18, 0, 0);
    vecs[8]  = mk(1,0,1,32'h40,1,32'h80, 32'h40, 32'h0, 32'h18, 0, 0);
    vecs[9]  = mk(0,0,0,0,0,0, 32'h44, mem(32'h40), 32'h44, 1, 0);
    vecs[10] = mk(0,0,0,0,1,32'h100, 32'h100, 32'h0, 32'h48, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    vecs[11] = mk(0,0,0,0,1,32'h42, 32'h8000_0180, 32'h0, 32'h104, 0, 1);
    vecs[12] = mk(0,0,0,0,0,0, 32'h8000_0184, mem(32'h8000_0180), 32'h8000_0184, 1, 0);
    vecs[13] = mk(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h0, 32'h8000_0188, 0, 0);
`else
    vecs[11] = mk(0,0,0,0,1,32'h42, 32'h40, 32'h0, 32'h104, 0, 0);
    vecs[12] = mk(0,0,0,0,0,0, 32'h44, mem(32'h40), 32'h44, 1, 0);
    vecs[13] = mk(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h0, 32'h48, 0, 0);
`endif
    vecs[14] = mk(0,0,0,0,0,0, 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1, 0);
    vecs[15] = mk(0,0,0,0,0,0, 32'h4, mem(32'h0), 32'h4, 1, 0);

    // Reset held for three cycles
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc",    imem_addr,   32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4",   if_id_pc4,   32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    chk("rst_err",   32'(addr_err), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_pc",    imem_addr, 32'h0);
    chk("rel_valid", 32'(if_id_valid), 32'h0);

    // Table-driven main sequence
    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl;
      branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump = vecs[i].jp; jump_target = vecs[i].jt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),    imem_addr,   vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i),   if_id_pc4,   vecs[i].e_pc4);
      chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
`ifdef PC_ALIGN_CHECK_EN
      chk($sformatf("v%0d_err", i),   32'(addr_err), 32'(vecs[i].e_err));
`endif
      @(negedge clk);
    end
    idle_inputs();

    // Reset asserted mid-stall: clears asynchronously, stall is discarded
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("async_pc",    imem_addr,   32'h0);
    chk("async_instr", if_id_instr, 32'h0);
    chk("async_pc4",   if_id_pc4,   32'h0);
    chk("async_valid", 32'(if_id_valid), 32'h0);
    @(negedge clk);
    stall = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_stall_pc",    imem_addr, 32'h4);
    chk("post_stall_pc4",   if_id_pc4, 32'h4);
    chk("post_stall_valid", 32'(if_id_valid), 32'h1);
    chk("post_stall_instr", if_id_instr, mem(32'h0));

    // Reset asserted mid-redirect: pending branch is dropped
    @(negedge clk);
    branch_taken = 1'b1;
    branch_target = 32'h200;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("redir_rst_pc",    imem_addr, 32'h0);
    chk("redir_rst_valid", 32'(if_id_valid), 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("redir_rel_pc",  imem_addr, 32'h4);
    chk("redir_rel_pc4", if_id_pc4, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
